// File: rtl/ntt_mod_mul.sv
// Four-stage Barrett modular multiplier feeding the NTT add_sub butterfly.
// Optional MOD_MUL_CENTERED_EN: out[1] in centered range instead of [0, Q).
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef Q
`define Q 3329
`endif

module ntt_mod_mul #(
   parameter int          BARRETT_K     = 2*`DATA_WIDTH,
   parameter logic [63:0] BARRETT_M     = (64'd1 << BARRETT_K) / 64'(`Q),
   parameter int          MUL_STAGE_CNT = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          en,
   input  logic                          in_valid,
   input  logic signed [`DATA_WIDTH-1:0] in [2],
   input  logic signed [`DATA_WIDTH-1:0] tw,
   output logic                          out_valid,
   output logic signed [`DATA_WIDTH-1:0] out [2]
);

   localparam int DW = `DATA_WIDTH;
   localparam int PW = 2*DW;
   localparam int XW = PW + 64;
   localparam logic [DW-1:0] QV   = DW'(`Q);
   localparam logic [DW-1:0] HALF = DW'((`Q+1)/2);

   if (MUL_STAGE_CNT != 4) begin : g_bad_depth
      $error("ntt_mod_mul: MUL_STAGE_CNT must be 4");
   end
   if (`Q >= (1 << (`DATA_WIDTH-1))) begin : g_bad_q
      $error("ntt_mod_mul: Q must be below 2^(DATA_WIDTH-1)");
   end

   logic [DW-1:0]        a_q, w_q;
   logic [PW-1:0]        p2_q, p3_q, qh3_q;
   logic signed [DW-1:0] d1_q, d2_q, d3_q;
   logic                 v1_q, v2_q, v3_q;

   logic [DW-1:0] a_n, w_n;
   logic [PW-1:0] p_n;
   logic [XW-1:0] prod, prod_sh;
   logic [PW-1:0] r_n, r1;
   logic [DW-1:0] rr, res;
   logic          unused_bits;

   // Map signed inputs in (-Q, Q) to canonical [0, Q).
   assign a_n = in[1][DW-1] ? $unsigned(in[1]) + QV : $unsigned(in[1]);
   assign w_n = tw[DW-1] ? $unsigned(tw) + QV : $unsigned(tw);

   assign p_n = PW'(a_q) * PW'(w_q);

   // Full-width product before the shift keeps the quotient estimate exact.
   assign prod    = XW'(p2_q) * XW'(BARRETT_M);
   assign prod_sh = prod >> BARRETT_K;

   assign r_n = p3_q - qh3_q * PW'(QV);
   assign r1  = (r_n >= PW'(QV)) ? r_n - PW'(QV) : r_n;
   assign rr  = r1[DW-1:0];

`ifdef MOD_MUL_CENTERED_EN
   assign res = (rr >= HALF) ? rr - QV : rr;
`else
   assign res = rr;
`endif

   assign unused_bits = ^{prod_sh[XW-1:PW], r1[PW-1:DW], HALF};

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q       <= '0;
         w_q       <= '0;
         d1_q      <= '0;
         v1_q      <= 1'b0;
         p2_q      <= '0;
         d2_q      <= '0;
         v2_q      <= 1'b0;
         p3_q      <= '0;
         qh3_q     <= '0;
         d3_q      <= '0;
         v3_q      <= 1'b0;
         out[0]    <= '0;
         out[1]    <= '0;
         out_valid <= 1'b0;
      end else if (en) begin
         a_q       <= a_n;
         w_q       <= w_n;
         d1_q      <= in[0];
         v1_q      <= in_valid;
         p2_q      <= p_n;
         d2_q      <= d1_q;
         v2_q      <= v1_q;
         p3_q      <= p2_q;
         qh3_q     <= prod_sh[PW-1:0];
         d3_q      <= d2_q;
         v3_q      <= v2_q;
         out[0]    <= d3_q;
         out[1]    <= $signed(res);
         out_valid <= v3_q;
      end
   end

endmodule

// File: tb/tb_ntt_mod_mul.sv
// Scoreboard bench for ntt_mod_mul: posedge input sampler fills the queue,
// negedge monitor pops and checks value, latency, stall hold and reset.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef Q
`define Q 3329
`endif

module tb_ntt_mod_mul;

   localparam int Q = `Q;

   typedef struct {
      int o0;
      int o1;
      int due;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en = 1'b1;
   logic in_valid = 1'b0;
   logic signed [`DATA_WIDTH-1:0] in_d [2];
   logic signed [`DATA_WIDTH-1:0] tw_d;
   logic out_valid;
   logic signed [`DATA_WIDTH-1:0] out_d [2];

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   adv_cnt = 0;
   bit   last_rst = 1'b0;
   bit   last_adv = 1'b0;
   bit   hold_v = 1'b0;
   int   hold0 = 0;
   int   hold1 = 0;

   ntt_mod_mul dut (
      .clk(clk),
      .rst(rst),
      .en(en),
      .in_valid(in_valid),
      .in(in_d),
      .tw(tw_d),
      .out_valid(out_valid),
      .out(out_d)
   );

   always #5 clk = ~clk;

   function automatic int ref_mul(input int a, input int b);
      int r;
      r = (a * b) % Q;
      if (r < 0) r += Q;
`ifdef MOD_MUL_CENTERED_EN
      if (r >= (Q + 1) / 2) r -= Q;
`endif
      return r;
   endfunction

   function automatic int rnd();
      return int'($urandom_range(2*Q-2)) - (Q - 1);
   endfunction

   // Input sampler: records what the DUT accepts on each enabled edge.
   always @(posedge clk) begin
      last_rst = rst;
      last_adv = en && !rst;
      if (rst) begin
         q.delete();
      end else if (en) begin
         adv_cnt++;
         if (in_valid) begin
            exp_t e;
            e.o0  = int'(in_d[0]);
            e.o1  = ref_mul(int'(in_d[1]), int'(tw_d));
            e.due = adv_cnt + 3;
            q.push_back(e);
         end
      end
   end

   // Output monitor.
   always @(negedge clk) begin
      if (last_rst) begin
         checks++;
         if (out_valid !== 1'b0 || out_d[0] !== '0 || out_d[1] !== '0) begin
            errors++;
            $display("FAIL reset: got v=%0b out={%0d,%0d} want v=0 out={0,0}",
                     out_valid, out_d[0], out_d[1]);
         end
         hold_v = 1'b0;
      end else if (last_adv) begin
         bit exp_v;
         exp_v = (q.size() > 0) && (q[0].due == adv_cnt);
         checks++;
         if (out_valid !== exp_v) begin
            errors++;
            $display("FAIL valid: got %0b want %0b at cycle %0d",
                     out_valid, exp_v, adv_cnt);
         end
         hold_v = exp_v;
         if (exp_v) begin
            exp_t e;
            e = q.pop_front();
            hold0 = e.o0;
            hold1 = e.o1;
            if (out_valid === 1'b1) begin
               checks++;
               if (int'(out_d[0]) != e.o0 || int'(out_d[1]) != e.o1) begin
                  errors++;
                  $display("FAIL data: got {%0d,%0d} want {%0d,%0d}",
                           out_d[0], out_d[1], e.o0, e.o1);
               end
            end
         end
      end else if (adv_cnt > 0) begin
         checks++;
         if (out_valid !== hold_v ||
             (hold_v && (int'(out_d[0]) != hold0 ||
                         int'(out_d[1]) != hold1))) begin
            errors++;
            $display("FAIL stall: got v=%0b {%0d,%0d} want v=%0b {%0d,%0d}",
                     out_valid, out_d[0], out_d[1], hold_v, hold0, hold1);
         end
      end
   end

   task automatic drive(input logic r, input logic e, input logic v,
                        input int a0, input int a1, input int t);
      @(posedge clk);
      #1;
      rst      = r;
      en       = e;
      in_valid = v;
      in_d[0]  = 16'(a0);
      in_d[1]  = 16'(a1);
      tw_d     = 16'(t);
   endtask

   task automatic op(input int a0, input int a1, input int t);
      drive(1'b0, 1'b1, 1'b1, a0, a1, t);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b0, 0, 0, 0);
   endtask

   initial begin
      in_d[0] = '0;
      in_d[1] = '0;
      tw_d    = '0;
      drive(1'b1, 1'b1, 1'b0, 0, 0, 0);
      drive(1'b1, 1'b1, 1'b0, 0, 0, 0);
      idle(2);

      op(5, 3328, 3328);
      idle(6);
      op(-7, -1, 17);
      idle(6);

      for (int i = 0; i < 8; i++) op(rnd(), -3328 + i, 1);
      idle(6);

      op(11, 0, 1234);
      op(-12, 2000, 0);
      op(13, -(Q - 1), 1);
      op(14, -(Q - 1), -(Q - 1));
      op(-(Q - 1), Q - 1, Q - 1);
      idle(6);

      for (int i = 0; i < 3; i++) op(rnd(), rnd(), rnd());
      for (int i = 0; i < 3; i++)
         drive(1'b0, 1'b0, 1'($urandom_range(1)), rnd(), rnd(), rnd());
      for (int i = 0; i < 3; i++) op(rnd(), rnd(), rnd());
      idle(6);

      for (int i = 0; i < 3; i++) op(rnd(), rnd(), rnd());
      drive(1'b1, 1'b1, 1'b1, rnd(), rnd(), rnd());
      idle(3);
      op(21, 100, 200);
      idle(6);

      for (int i = 0; i < 20; i++)
         drive(1'b0, 1'b1, 1'b0, rnd(), rnd(), rnd());

      for (int i = 0; i < 10000; i++) begin
         logic e;
         logic v;
         e = ($urandom_range(9) != 0);
         v = ($urandom_range(7) != 0);
         drive(1'b0, e, v, rnd(), rnd(), rnd());
      end

      idle(20);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending want 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
